pid_core: RTL and testbench

PID_CORE -- requirements
Module: pid_core

---
 rtl/segway_pkg.sv | 11 +
 rtl/err_queue.sv | 21 ++
 rtl/pid_core.sv | 82 ++++++++
 tb/tb_pid_core.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/segway_pkg.sv
// segway_pkg: shared saturation limits and integrator geometry for the segway control path
package segway_pkg;
    localparam int SAT7_MAX  = 63;
    localparam int SAT7_MIN  = -64;
    localparam int SAT10_MAX = 511;
    localparam int SAT10_MIN = -512;
    localparam int SAT12_MAX = 2047;
    localparam int SAT12_MIN = -2048;
    localparam int INTEG_W   = 18;
    localparam int I_SHIFT   = 6;
endpackage

// File: rtl/err_queue.sv
// err_queue: shift queue of past error samples; oldest exposes the entry about to fall off
module err_queue #(
    parameter int DEPTH = 2,
    parameter int W     = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic signed [W-1:0] din,
    output logic signed [W-1:0] oldest
);
    logic signed [W-1:0] q [DEPTH];
    always_ff @(posedge clk) begin
        if (rst) q <= '{default: '0};
        else if (push) begin
            q[0] <= din;
            for (int i = 1; i < DEPTH; i++) q[i] <= q[i-1];
        end
    end
    assign oldest = q[DEPTH-1];
endmodule

// File: rtl/pid_core.sv
// pid_core: two-stage pipelined PID producing a saturated 12-bit control word
// Integrator present only when PID_I_TERM_EN is defined; otherwise I_term is 0 and pwr_up is ignored.
module pid_core
    import segway_pkg::*;
#(
    parameter logic [4:0] P_COEFF       = 5'h0C,
    parameter logic [5:0] D_COEFF       = 6'h14,
    parameter int         D_QUEUE_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vld,
    input  logic signed [9:0]  ptch_err_sat,
    input  logic               pwr_up,
    output logic signed [11:0] PID_cntrl,
    output logic               cntrl_vld
);
    logic signed [9:0]  prev_err;
    logic signed [10:0] d_diff;
    logic signed [6:0]  d_sat;
    logic signed [12:0] d_term, d_r;
    logic signed [14:0] p_term, p_r;
    logic signed [11:0] i_term, i_r;
    logic signed [15:0] sum;
    logic               s1_vld;

    err_queue #(.DEPTH(D_QUEUE_DEPTH), .W(10)) u_queue (
        .clk    (clk),
        .rst    (rst),
        .push   (vld),
        .din    (ptch_err_sat),
        .oldest (prev_err)
    );

    assign d_diff = {ptch_err_sat[9], ptch_err_sat} - {prev_err[9], prev_err};
    assign d_sat  = d_diff > SAT7_MAX ? 7'(SAT7_MAX) : d_diff < SAT7_MIN ? 7'(SAT7_MIN) : d_diff[6:0];
    assign d_term = 13'(d_sat) * 13'($signed({1'b0, D_COEFF}));
    assign p_term = 15'(ptch_err_sat) * 15'($signed({1'b0, P_COEFF}));

`ifdef PID_I_TERM_EN
    logic signed [INTEG_W-1:0] integ, integ_sum, integ_nxt;
    logic                      ovf;
    assign integ_sum = integ + INTEG_W'(ptch_err_sat);
    // Same-sign operands with a flipped result sign means the add wrapped; hold instead.
    assign ovf       = (integ[INTEG_W-1] == ptch_err_sat[9]) && (integ_sum[INTEG_W-1] != integ[INTEG_W-1]);
    assign integ_nxt = !pwr_up ? '0 : (vld && !ovf) ? integ_sum : integ;
    assign i_term    = integ_nxt[I_SHIFT +: 12];
    always_ff @(posedge clk) integ <= rst ? '0 : integ_nxt;
`else
    logic unused_pwr_up;
    assign unused_pwr_up = pwr_up;
    assign i_term        = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            p_r    <= '0;
            i_r    <= '0;
            d_r    <= '0;
        end else begin
            s1_vld <= vld;
            if (vld) begin
                p_r <= p_term;
                i_r <= i_term;
                d_r <= d_term;
            end
        end
    end

    assign sum = 16'(p_r) + 16'(i_r) + 16'(d_r);

    always_ff @(posedge clk) begin
        if (rst) begin
            PID_cntrl <= '0;
            cntrl_vld <= 1'b0;
        end else begin
            cntrl_vld <= s1_vld;
            if (s1_vld) PID_cntrl <= sum > SAT12_MAX ? 12'h7FF : sum < SAT12_MIN ? 12'h800 : sum[11:0];
        end
    end
endmodule

// File: tb/tb_pid_core.sv
// tb_pid_core: scoreboard bench for pid_core; expected words queued at issue, checked by a negedge monitor
// Expectations follow the PID_I_TERM_EN setting of the build.
module tb_pid_core;
    localparam int DQ   = 2;
    localparam int NONE = -99999;
`ifdef PID_I_TERM_EN
    localparam int H1 = 764;
    localparam int H2 = 2044;
`else
    localparam int H1 = -1280;
    localparam int H2 = 0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               vld = 1'b0;
    logic               pwr_up = 1'b1;
    logic signed [9:0]  ptch_err_sat = '0;
    logic signed [11:0] PID_cntrl;
    logic               cntrl_vld;

    typedef struct {
        int          cyc;
        logic [11:0] val;
    } exp_t;

    exp_t        sb[$];
    int          mq[DQ];
    int          integ = 0;
    logic [11:0] m_hold = '0;
    int          ncyc = 0;
    int          checks = 0;
    int          errors = 0;

    pid_core #(.P_COEFF(5'h0C), .D_COEFF(6'h14), .D_QUEUE_DEPTH(DQ)) dut (
        .clk          (clk),
        .rst          (rst),
        .vld          (vld),
        .ptch_err_sat (ptch_err_sat),
        .pwr_up       (pwr_up),
        .PID_cntrl    (PID_cntrl),
        .cntrl_vld    (cntrl_vld)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int v, input int lo, input int hi);
        return v > hi ? hi : v < lo ? lo : v;
    endfunction

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, ncyc, act, exp);
        end
    endtask

    // One clock of stimulus; the reference state advances at the same edge the DUT samples.
    task automatic drive(input logic v, input int e, input logic p, input logic r, input int hand);
        int n, prev, d, tot;
        n            = ncyc;
        rst          = r;
        vld          = v;
        pwr_up       = p;
        ptch_err_sat = 10'(e);
        @(posedge clk);
        if (r) begin
            mq     = '{default: 0};
            integ  = 0;
            m_hold = '0;
            sb.delete();
        end else begin
`ifdef PID_I_TERM_EN
            if (!p) integ = 0;
            else if (v && integ + e <= 131071 && integ + e >= -131072) integ = integ + e;
`endif
            if (v) begin
                prev = mq[DQ-1];
                for (int i = DQ - 1; i > 0; i--) mq[i] = mq[i-1];
                mq[0] = e;
                d   = sat(e - prev, -64, 63) * 20;
                tot = sat(e * 12 + (integ >>> 6) + d, -2048, 2047);
                sb.push_back('{n + 2, hand == NONE ? 12'(tot) : 12'(hand)});
            end
        end
        #1;
    endtask

    task automatic idle(input int k, input logic p);
        repeat (k) drive(1'b0, 0, p, 1'b0, NONE);
    endtask

    task automatic reset_dut();
        repeat (2) drive(1'b0, 0, 1'b1, 1'b1, NONE);
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (sb.size() != 0 && sb[0].cyc == ncyc) begin
            x = sb.pop_front();
            chk("cntrl_vld_strobe", {11'd0, cntrl_vld}, 12'd1);
            chk("PID_cntrl", PID_cntrl, x.val);
            m_hold = x.val;
        end else begin
            chk("cntrl_vld_idle", {11'd0, cntrl_vld}, 12'd0);
            chk("PID_cntrl_hold", PID_cntrl, m_hold);
        end
        ncyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int pat[6] = '{3, -7, 50, -50, 0, 200};
        reset_dut();
        idle(2, 1'b1);
        drive(1'b1, 10, 1'b1, 1'b0, 320);
        idle(3, 1'b1);
        reset_dut();
        drive(1'b1, 100, 1'b1, 1'b0, 2047);
        idle(2, 1'b1);
        repeat (3) drive(1'b1, -512, 1'b1, 1'b0, -2048);
        idle(2, 1'b1);
        foreach (pat[i]) begin
            drive(1'b1, pat[i], 1'b1, 1'b0, NONE);
            if (i % 2 == 1) idle(1, 1'b1);
        end
        idle(3, 1'b1);
        reset_dut();
        drive(1'b1, 10, 1'b1, 1'b0, NONE);
        drive(1'b0, 0, 1'b1, 1'b1, NONE);
        idle(3, 1'b1);
        drive(1'b1, 10, 1'b1, 1'b0, 320);
        idle(3, 1'b1);
        reset_dut();
        repeat (257) drive(1'b1, 511, 1'b1, 1'b0, 2047);
        drive(1'b1, 0, 1'b1, 1'b0, H1);
        drive(1'b1, 0, 1'b1, 1'b0, H1);
        drive(1'b1, 0, 1'b1, 1'b0, H2);
        idle(2, 1'b1);
        idle(1, 1'b0);
        drive(1'b1, 0, 1'b0, 1'b0, 0);
        drive(1'b1, 0, 1'b1, 1'b0, 0);
        idle(4, 1'b1);
        chk("scoreboard_drained", 12'(sb.size()), 12'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
